oagu_add: RTL and testbench

- Output address generator for the element-wise ADD layer; write-side counterpart of the ADD input address generator.
- Takes result beats from the adder datapath and writes them into the IO buffer in raster order: x fastest, then y, then piece.
- Each beat gets a 13-bit write address, a write enable and the data word.
- Signals end-of-feature to the scheduler once the last result is written.

---
 rtl/oagu_add.sv | 129 ++++++++++++
 tb/tb_oagu_add.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/oagu_add.sv
// rtl/oagu_add.sv - ADD-layer output address generator: raster-order IO buffer writes.
// Build option OAGU_ADD_RELU_EN clamps negative results to zero on the write path.
module oagu_add #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic [ADDR_W-1:0] addr_start_o,
  input  logic [LEN_W-1:0]  out_x_length,
  input  logic [LEN_W-1:0]  out_y_length,
  input  logic [LEN_W-1:0]  out_piece,
  input  logic [LEN_W-1:0]  row_stride,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_feature_end
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  cfg_x, cfg_y, cfg_p, stride;
  logic [LEN_W-1:0]  x_cnt, y_cnt, p_cnt;
  logic [ADDR_W-1:0] cur_addr, row_base;
  logic              fin;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [ADDR_W-1:0] next_row;
  logic              zero_len;

  always_comb begin
    wr_data_nxt = i_data;
`ifdef OAGU_ADD_RELU_EN
    if (i_data[DATA_W-1]) wr_data_nxt = '0;
`endif
  end

  assign next_row = row_base + {{(ADDR_W-LEN_W){1'b0}}, stride};
  assign zero_len = (out_x_length == '0) || (out_y_length == '0) || (out_piece == '0);

  // fin marks that the last beat has been registered; RUN lingers one cycle so the
  // final write stays inside RUN and o_busy drops together with o_feature_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_x         <= '0;
      cfg_y         <= '0;
      cfg_p         <= '0;
      stride        <= '0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      p_cnt         <= '0;
      cur_addr      <= '0;
      row_base      <= '0;
      fin           <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_en       <= 1'b0;
      o_wr_data     <= '0;
      o_busy        <= 1'b0;
      o_feature_end <= 1'b0;
    end else begin
      o_wr_en       <= 1'b0;
      o_feature_end <= 1'b0;
      case (state)
        IDLE: begin
          if (start_calculate) begin
            cfg_x    <= out_x_length;
            cfg_y    <= out_y_length;
            cfg_p    <= out_piece;
            stride   <= (row_stride == '0) ? out_x_length : row_stride;
            x_cnt    <= '0;
            y_cnt    <= '0;
            p_cnt    <= '0;
            cur_addr <= addr_start_o;
            row_base <= addr_start_o;
            fin      <= 1'b0;
            if (zero_len) begin
              state         <= DONE;
              o_feature_end <= 1'b1;
            end else begin
              state  <= RUN;
              o_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fin) begin
            state         <= DONE;
            o_busy        <= 1'b0;
            o_feature_end <= 1'b1;
          end else if (i_valid) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= cur_addr;
            o_wr_data <= wr_data_nxt;
            if (x_cnt != cfg_x - LEN_W'(1)) begin
              x_cnt    <= x_cnt + LEN_W'(1);
              cur_addr <= cur_addr + ADDR_W'(1);
            end else begin
              x_cnt    <= '0;
              row_base <= next_row;
              cur_addr <= next_row;
              if (y_cnt != cfg_y - LEN_W'(1)) begin
                y_cnt <= y_cnt + LEN_W'(1);
              end else begin
                y_cnt <= '0;
                if (p_cnt != cfg_p - LEN_W'(1)) begin
                  p_cnt <= p_cnt + LEN_W'(1);
                end else begin
                  p_cnt <= '0;
                  fin   <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          fin   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oagu_add.sv
// tb/tb_oagu_add.sv - job-table bench for oagu_add with write/end-pulse scoreboards.
module tb_oagu_add;

  logic        clk = 0;
  logic        rst;
  logic        start_calculate;
  logic [12:0] addr_start_o;
  logic [7:0]  out_x_length, out_y_length, out_piece, row_stride;
  logic        i_valid;
  logic [15:0] i_data;
  logic [12:0] o_wr_addr;
  logic        o_wr_en;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic        o_feature_end;

  oagu_add dut (
    .clk(clk), .rst(rst), .start_calculate(start_calculate),
    .addr_start_o(addr_start_o), .out_x_length(out_x_length),
    .out_y_length(out_y_length), .out_piece(out_piece), .row_stride(row_stride),
    .i_valid(i_valid), .i_data(i_data), .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_feature_end(o_feature_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [12:0] base;
    logic [7:0]  x, y, p, stride;
    int          gap;    // -1: random 0..2 idle cycles between beats
    int          dmode;  // 0: 1..N, 1: random, 2: ReLU corner values
    bit          xstart; // extra start_calculate mid-run
  } job_t;

  wr_t wq[$];
  int  eq[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic logic [15:0] exp_data(input logic [15:0] d);
`ifdef OAGU_ADD_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_wr_en) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = wq.pop_front();
        check("wr_addr", o_wr_addr, e.addr);
        check("wr_data", o_wr_data, e.data);
        check("wr_latency", cyc, e.cyc);
      end
    end
    if (o_feature_end) begin
      if (eq.size() == 0) begin
        check("unexpected_end", 1, 0);
      end else begin
        check("end_cycle", cyc, eq.pop_front());
        check("busy_at_end", o_busy, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j);
    logic [15:0] relu_vals [4];
    logic [7:0]  s;
    logic [12:0] a;
    logic [15:0] d;
    int          idx, last, g;
    bit          zero;
    relu_vals[0] = 16'hFFFD; relu_vals[1] = 16'h0007;
    relu_vals[2] = 16'h8000; relu_vals[3] = 16'h0000;
    zero = (j.x == 0) || (j.y == 0) || (j.p == 0);
    s = (j.stride == 0) ? j.x : j.stride;
    addr_start_o = j.base; out_x_length = j.x; out_y_length = j.y;
    out_piece = j.p; row_stride = j.stride; start_calculate = 1;
    if (zero) begin
      eq.push_back(cyc + 1);
      step();
      start_calculate = 0;
    end else begin
      idx = 0;
      last = 0;
      for (int p = 0; p < int'(j.p); p++)
        for (int y = 0; y < int'(j.y); y++)
          for (int x = 0; x < int'(j.x); x++) begin
            step();
            start_calculate = 0;
            i_valid = 0;
            if (idx == 0) begin
              @(negedge clk);
              check("busy_in_run", o_busy, 1);
            end
            if (idx > 0) begin
              g = (j.gap < 0) ? $urandom_range(0, 2) : j.gap;
              for (int k = 0; k < g; k++) step();
            end
            if (j.xstart && idx == 1) begin
              start_calculate = 1;
              addr_start_o = 13'h0ABC;
              out_x_length = 8'd1;
            end else begin
              start_calculate = 0;
            end
            case (j.dmode)
              0: d = 16'(idx + 1);
              2: d = relu_vals[idx % 4];
              default: d = 16'($urandom);
            endcase
            a = j.base + 13'((p * int'(j.y) + y) * int'(s) + x);
            i_valid = 1;
            i_data = d;
            wq.push_back('{a, exp_data(d), cyc + 1});
            last = cyc;
            idx++;
          end
      eq.push_back(last + 2);
      step();
      start_calculate = 0;
      i_data = 16'h5A5A;  // beat after the last one must be ignored
      step();
      i_valid = 0;
    end
    for (int k = 0; k < 64 && (wq.size() != 0 || eq.size() != 0); k++) step();
    if (wq.size() != 0 || eq.size() != 0) begin
      check("job_timeout", wq.size() + eq.size(), 0);
      wq.delete();
      eq.delete();
    end
    for (int k = 0; k < 3; k++) step();
  endtask

  job_t jobs [10];

  initial begin
    jobs[0] = '{13'h0000, 8'd2, 8'd2, 8'd2, 8'd0,   0, 0, 1'b0};
    jobs[1] = '{13'h0100, 8'd3, 8'd2, 8'd1, 8'd5,   0, 1, 1'b0};
    jobs[2] = '{13'h0040, 8'd2, 8'd1, 8'd1, 8'd0,   2, 1, 1'b0};
    jobs[3] = '{13'h0010, 8'd3, 8'd0, 8'd2, 8'd0,   0, 1, 1'b0};
    jobs[4] = '{13'h0200, 8'd3, 8'd2, 8'd2, 8'd0,   0, 1, 1'b1};
    jobs[5] = '{13'h1FFE, 8'd4, 8'd1, 8'd1, 8'd0,   0, 1, 1'b0};
    jobs[6] = '{13'h0300, 8'd4, 8'd1, 8'd1, 8'd0,   0, 2, 1'b0};
    jobs[7] = '{13'h0020, 8'd3, 8'd3, 8'd2, 8'd7,  -1, 1, 1'b0};
    jobs[8] = '{13'h0000, 8'd0, 8'd4, 8'd4, 8'd0,   0, 1, 1'b0};
    jobs[9] = '{13'h1F00, 8'd2, 8'd3, 8'd2, 8'd255, 0, 1, 1'b0};

    rst = 1; start_calculate = 0; i_valid = 0; i_data = 0;
    addr_start_o = 0; out_x_length = 0; out_y_length = 0; out_piece = 0; row_stride = 0;
    step(); step(); step();
    @(negedge clk);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_end", o_feature_end, 0);
    step();
    rst = 0;
    step();

    for (int i = 0; i < 10; i++) run_job(jobs[i]);

    // Reset in the middle of a 4-beat job: third beat is dropped, no end pulse.
    addr_start_o = 13'h0400; out_x_length = 8'd4; out_y_length = 8'd1;
    out_piece = 8'd1; row_stride = 8'd0; start_calculate = 1;
    step();
    start_calculate = 0;
    i_valid = 1; i_data = 16'h1111;
    wq.push_back('{13'h0400, exp_data(16'h1111), cyc + 1});
    step();
    i_data = 16'h2222;
    wq.push_back('{13'h0401, exp_data(16'h2222), cyc + 1});
    step();
    rst = 1; i_data = 16'h3333;
    step();
    rst = 0; i_valid = 0;
    @(negedge clk);
    check("midrst_wr_en", o_wr_en, 0);
    check("midrst_wr_addr", o_wr_addr, 0);
    check("midrst_wr_data", o_wr_data, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_end", o_feature_end, 0);
    for (int k = 0; k < 8; k++) step();
    check("midrst_pending", wq.size(), 0);
    wq.delete();

    run_job(jobs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
